weight_fetch: RTL and testbench
===============================

# weight_fetch

Read-side sequencer for the PE weight scratch pad. Drives the scratch-pad read address (port B), absorbs the 1-cycle RAM read latency, and streams weights to the PE MAC over a valid/ready interface. The stream covers `weight_num` weights per pass, repeated `pixel_num` times. During the first pass it never reads an address the loader has not yet written.

## Interface
- `DATA_WIDTH`, 16, weight word width
- `ADDRESSWIDTH_W_PAD`, 8, scratch-pad address width
- `ADDRESSWIDTH_F_PAD`, 8, pixel-count width
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `fetch_start`  in  1  one-cycle pulse; latches `weight_num` and `pixel_num`; ignored unless idle
- `weight_num`  in  ADDRESSWIDTH_W_PAD  weights per pass
- `pixel_num`  in  ADDRESSWIDTH_F_PAD  number of passes
- `wr_ptr`  in  ADDRESSWIDTH_W_PAD  loader write pointer; addresses below it are valid
- `load_done`  in  1  loader finished; whole pad valid
- `raddr`  out  ADDRESSWIDTH_W_PAD  scratch-pad read address (registered)
- `rdata`  in  DATA_WIDTH  scratch-pad read data; valid one cycle after `raddr` is sampled
- `w_valid`  out  1  output weight valid
- `w_ready`  in  1  MAC accepts weight
- `w_data`  out  DATA_WIDTH  weight
- `w_last`  out  1  last weight of a pass
- `w_final`  out  1  last weight of last pass
- `busy`  out  1  not idle
- `done`  out  1  one-cycle pulse when all weights have been accepted

## Operation
- **FSM states:** IDLE, FETCH, DRAIN.
- **IDLE, on `fetch_start`:**
  - If `weight_num==0` or `pixel_num==0`: pulse `done` next cycle and stay in IDLE.
  - Otherwise: latch both counts, set `raddr=0` and `pass_cnt=0`, then go to FETCH.
- **Issue condition in FETCH** (all must hold):
  - Credit: `occ + inflight <= 2`, where `occ` is the registered FIFO occupancy and `inflight` is 0 or 1.
  - Availability: `pass_cnt!=0 || load_done || raddr < wr_ptr`.
- **On issue:**
  - Tag the word with `last = (raddr==weight_num-1)` and `final = last && (pass_cnt==pixel_num-1)`.
  - If `last`: set `raddr<=0` and increment `pass_cnt`. If `final`, go to DRAIN.
  - Otherwise: `raddr<=raddr+1`.
- **Return path:** one cycle after issue, push `{final, last, rdata}` into the output FIFO.
- **DRAIN:** when the FIFO is empty and `inflight==0`, pulse `done` and return to IDLE.
- **Output:** `w_valid = !fifo_empty`; a pop occurs on `w_valid && w_ready`. `w_data`, `w_last` and `w_final` are held stable while `w_valid && !w_ready`.
- **Back-pressure:** `w_ready=0` indefinitely must cause no loss and no duplicate words.
- **`wr_ptr`:** only consulted in pass 0. Later passes assume the pad is fully written.
- **Arithmetic:** `raddr` is compared as unsigned. `weight_num` up to 2^ADDRESSWIDTH_W_PAD−1 is supported; `raddr` never wraps past `weight_num-1`.

## Timing
- **Reset values:** `raddr=0`, `w_valid=0`, `w_last=0`, `w_final=0`, `busy=0`, `done=0`. FIFO flushed, `inflight=0`, FSM=IDLE.
- **Reset mid-operation:** aborts immediately; no `done` pulse is produced.
- **Start latency:** `fetch_start` sampled at cycle 0 → first issue in cycle 1 (`raddr=0`) → `rdata` valid in cycle 2 → `w_valid` in cycle 3.
- **Throughput:** 1 weight/cycle sustained with `w_ready=1` and data available.
- **Completion:** `done` is asserted the cycle after the FIFO drains following the final pop. `busy` falls in the same cycle as `done`.
- **Simultaneous push and pop:** occupancy unchanged.
- **`fetch_start` while busy:** ignored; latched counts unchanged.

## Structure
- FSM state encodings and the credit threshold constant (2) go in the shared PE package.
- Output buffer: instantiate the existing `fifo` module with `DEPTH_WIDTH=2` (4 entries), width `DATA_WIDTH+2`.
- No other sub-modules.

## Test plan
- **Basic two-pass stream:** pad preloaded with 0x10..0x13, `weight_num=4`, `pixel_num=2`, `load_done=1`, `w_ready=1`
  → 8 beats 0x10..0x13,0x10..0x13; `w_last` on beats 4 and 8; `w_final` on beat 8 only; first `w_valid` 3 cycles after start; one `done` pulse.
- **Back-pressure:** same setup, `w_ready` random 50%
  → identical sequence; no drop or duplicate; outputs stable while stalled; FIFO never overflows.
- **Write-pointer gating:** `load_done=0`, `weight_num=6`, `wr_ptr` incremented 0→6 every 3 cycles
  → an issue at address A occurs only when `A < wr_ptr`; the stream completes correctly.
- **Zero count:** `weight_num=0` (or `pixel_num=0`) with `fetch_start`
  → `done` next cycle, `w_valid` never asserted, `busy` stays 0.
- **Reset mid-run:** `rst` asserted after 3 accepted beats
  → all outputs at reset values; a subsequent start replays from `raddr=0` correctly.
- **Start while busy:** second `fetch_start` mid-stream with different counts
  → ignored; original stream and a single `done` pulse.

Source files
------------

// File: rtl/weight_fetch_pkg.sv
// weight_fetch_pkg
// Shared PE definitions for the weight read sequencer: FSM state
// encodings, the read-credit threshold, the output-buffer depth and a
// credit helper used by the sequencer.
package weight_fetch_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    WF_IDLE  = 2'd0,
    WF_FETCH = 2'd1,
    WF_DRAIN = 2'd2
  } wf_state_e;

  // A new read may be issued while buffered + in-flight words <= this value.
  // With a 4-entry buffer this leaves room for the word already in flight.
  localparam int unsigned WF_CREDIT_MAX = 32'd2;

  // Output buffer is 2**WF_FIFO_DEPTH_WIDTH entries deep
  localparam int unsigned WF_FIFO_DEPTH_WIDTH = 32'd2;

  // True when one more read can be issued without risking buffer overflow
  function automatic logic wf_credit_ok(input logic [WF_FIFO_DEPTH_WIDTH:0] occ,
                                        input logic inflight);
    logic [WF_FIFO_DEPTH_WIDTH+1:0] sum;
    sum = {1'b0, occ} + {{(WF_FIFO_DEPTH_WIDTH + 1){1'b0}}, inflight};
    return (32'(sum) <= WF_CREDIT_MAX);
  endfunction

endpackage

// File: rtl/weight_fetch_fifo.sv
// fifo
// Small synchronous first-word-fall-through FIFO used as the output buffer
// of the weight sequencer. The head entry is presented on dout_o whenever
// empty_o is low and only changes on a pop, so it stays stable while the
// consumer stalls. Pushes into a full FIFO and pops from an empty one are
// dropped.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (flushes contents)
//   push_i, din_i write strobe and data
//   pop_i         remove head entry
//   dout_o        head entry
//   empty_o       no entries
//   full_o        all entries used
//   count_o       registered occupancy
module fifo #(
  parameter int WIDTH       = 18,
  parameter int DEPTH_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [DEPTH_WIDTH:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q;
  logic [DEPTH_WIDTH:0]   count_q;
  logic                   do_push_s;
  logic                   do_pop_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (DEPTH_WIDTH + 1)'(DEPTH));
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign dout_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage array write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_WIDTH'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_WIDTH'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (DEPTH_WIDTH + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_WIDTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetch.sv
// weight_fetch
// Read-side sequencer for the PE weight scratch pad. Walks the pad from
// address 0 to weight_num-1, pixel_num times, absorbs the one-cycle RAM read
// latency and streams the words to the MAC over valid/ready. During the first
// pass an address is only read once the loader has written it.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fetch_start              start pulse, accepted only when idle
//   weight_num, pixel_num    weights per pass, number of passes
//   wr_ptr, load_done        loader progress (addresses below wr_ptr valid)
//   raddr / rdata            scratch-pad port B address / data (+1 cycle)
//   w_valid/w_ready/w_data   weight stream to the MAC
//   w_last, w_final          last of a pass, last of the whole stream
//   busy, done               not idle, one-cycle completion pulse
module weight_fetch
  import weight_fetch_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDRESSWIDTH_W_PAD = 8,
  parameter int ADDRESSWIDTH_F_PAD = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_start,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num,
  input  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] wr_ptr,
  input  logic                          load_done,
  output logic [ADDRESSWIDTH_W_PAD-1:0] raddr,
  input  logic [DATA_WIDTH-1:0]         rdata,
  output logic                          w_valid,
  input  logic                          w_ready,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          w_last,
  output logic                          w_final,
  output logic                          busy,
  output logic                          done
);

  localparam int FW = DATA_WIDTH + 2;
  localparam int AW = ADDRESSWIDTH_W_PAD;
  localparam int PW = ADDRESSWIDTH_F_PAD;

  wf_state_e state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d;
  logic [AW-1:0] wnum_q, wnum_d;
  logic [PW-1:0] pnum_q, pnum_d;
  logic          inflight_q, inflight_d;
  logic          tag_last_q, tag_last_d;
  logic          tag_final_q, tag_final_d;
  logic          done_q, done_d;

  logic                       issue_s;
  logic                       credit_s;
  logic                       avail_s;
  logic                       last_s;
  logic                       final_s;
  logic                       pop_s;
  logic                       fifo_empty_s;
  logic                       fifo_full_s;
  logic [FW-1:0]              fifo_dout_s;
  logic [WF_FIFO_DEPTH_WIDTH:0] fifo_count_s;

  assign credit_s = wf_credit_ok(fifo_count_s, inflight_q);
  // The write pointer only matters in pass 0; later passes see a full pad.
  assign avail_s  = (pass_cnt_q != '0) | load_done | (raddr_q < wr_ptr);
  assign last_s   = (raddr_q == (wnum_q - AW'(1)));
  assign final_s  = last_s & (pass_cnt_q == (pnum_q - PW'(1)));
  assign pop_s    = w_valid & w_ready;

  // Next-state, address walk and completion logic
  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    pass_cnt_d  = pass_cnt_q;
    wnum_d      = wnum_q;
    pnum_d      = pnum_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;
    case (state_q)
      WF_IDLE: begin
        if (fetch_start) begin
          if ((weight_num == '0) || (pixel_num == '0)) begin
            done_d = 1'b1;
          end else begin
            wnum_d     = weight_num;
            pnum_d     = pixel_num;
            raddr_d    = '0;
            pass_cnt_d = '0;
            state_d    = WF_FETCH;
          end
        end else begin
          state_d = WF_IDLE;
        end
      end
      WF_FETCH: begin
        if (credit_s && avail_s && !fifo_full_s) begin
          issue_s = 1'b1;
          if (last_s) begin
            raddr_d    = '0;
            pass_cnt_d = pass_cnt_q + PW'(1);
            if (final_s) begin
              state_d = WF_DRAIN;
            end else begin
              state_d = WF_FETCH;
            end
          end else begin
            raddr_d = raddr_q + AW'(1);
          end
        end else begin
          state_d = WF_FETCH;
        end
      end
      WF_DRAIN: begin
        if (fifo_empty_s && !inflight_q) begin
          done_d  = 1'b1;
          state_d = WF_IDLE;
        end else begin
          state_d = WF_DRAIN;
        end
      end
      default: begin
        state_d = WF_IDLE;
      end
    endcase
  end

  // Tags travel alongside the read so they line up with rdata next cycle
  always_comb begin
    inflight_d  = issue_s;
    tag_last_d  = issue_s & last_s;
    tag_final_d = issue_s & final_s;
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WF_IDLE;
      raddr_q     <= '0;
      pass_cnt_q  <= '0;
      wnum_q      <= '0;
      pnum_q      <= '0;
      inflight_q  <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_final_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      pass_cnt_q  <= pass_cnt_d;
      wnum_q      <= wnum_d;
      pnum_q      <= pnum_d;
      inflight_q  <= inflight_d;
      tag_last_q  <= tag_last_d;
      tag_final_q <= tag_final_d;
      done_q      <= done_d;
    end
  end

  fifo #(
    .WIDTH       (FW),
    .DEPTH_WIDTH (WF_FIFO_DEPTH_WIDTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   ({tag_final_q, tag_last_q, rdata}),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s),
    .count_o (fifo_count_s)
  );

  assign raddr   = raddr_q;
  assign w_valid = ~fifo_empty_s;
  assign w_data  = fifo_dout_s[DATA_WIDTH-1:0];
  // Tag bits are masked so they read 0 whenever no word is presented
  assign w_last  = w_valid & fifo_dout_s[DATA_WIDTH];
  assign w_final = w_valid & fifo_dout_s[DATA_WIDTH+1];
  assign busy    = (state_q != WF_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_weight_fetch.sv
module tb_weight_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [7:0]  weight_num;
  logic [7:0]  pixel_num;
  logic [7:0]  wr_ptr;
  logic        load_done;
  logic [7:0]  raddr;
  logic [15:0] rdata;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        w_last;
  logic        w_final;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  // Stream observations collected by run_stream
  logic [17:0] obs_q[$];
  int done_cnt, done_cyc, last_pop_cyc, first_valid_cyc, stall_breaks, done_busy_bad;
  logic busy_c1;
  bit timed_out;

  always #5 clk = ~clk;

  // Scratch-pad model: 1-cycle read latency, poisoned data for unwritten addresses
  always @(posedge clk) begin
    rdata <= (load_done || (raddr < wr_ptr)) ? mem[raddr] : 16'hDEAD;
  end

  weight_fetch #(
    .DATA_WIDTH(16), .ADDRESSWIDTH_W_PAD(8), .ADDRESSWIDTH_F_PAD(8)
  ) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .weight_num(weight_num),
    .pixel_num(pixel_num), .wr_ptr(wr_ptr), .load_done(load_done), .raddr(raddr),
    .rdata(rdata), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_last(w_last), .w_final(w_final), .busy(busy), .done(done)
  );

  // Reference model: the stream is pn passes over addresses 0..wn-1.
  // Returns number of beats differing from the observed stream.
  function automatic int count_bad(input int wn, input int pn);
    int bad = 0;
    int k = 0;
    logic [17:0] e;
    for (int p = 0; p < pn; p++) begin
      for (int a = 0; a < wn; a++) begin
        e = {(p == pn - 1) && (a == wn - 1), (a == wn - 1), mem[a]};
        if (k >= obs_q.size() || obs_q[k] !== e) bad++;
        k++;
      end
    end
    if (obs_q.size() > k) bad += obs_q.size() - k;
    return bad;
  endfunction

  // Starts a stream and observes it. cyc numbering: start sampled in cycle 0.
  task automatic run_stream(input int wn, input int pn, input int rpct, input bit gate,
                            input int restart_at, input int abort_beats);
    int cyc;
    int beats = 0;
    bit prev_stall = 1'b0;
    logic [17:0] prev_beat = '0;
    obs_q.delete();
    done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1;
    stall_breaks = 0; done_busy_bad = 0; busy_c1 = 1'b0; timed_out = 1'b1;
    weight_num = wn[7:0];
    pixel_num = pn[7:0];
    load_done = !gate;
    wr_ptr = 8'd0;
    w_ready = 1'b0;
    fetch_start = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      cyc = n + 1;
      fetch_start = 1'b0;
      if (cyc == 1) busy_c1 = busy;
      if (gate && (cyc % 3 == 0) && (int'(wr_ptr) < wn)) wr_ptr = wr_ptr + 8'd1;
      if (w_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && (w_valid !== 1'b1 || {w_final, w_last, w_data} !== prev_beat))
        stall_breaks++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy !== 1'b0) done_busy_bad++;
      end
      if (cyc == restart_at) begin
        fetch_start = 1'b1;
        weight_num = 8'd3;
        pixel_num = 8'd1;
      end
      if (abort_beats >= 0 && beats == abort_beats) begin
        timed_out = 1'b0;
        return;
      end
      w_ready = (int'($urandom_range(99)) < rpct);
      if (w_valid === 1'b1 && w_ready) begin
        obs_q.push_back({w_final, w_last, w_data});
        beats++;
        last_pop_cyc = cyc;
      end
      prev_stall = (w_valid === 1'b1) && !w_ready;
      prev_beat = {w_final, w_last, w_data};
      if (done_cyc > 0 && cyc >= done_cyc + 4) begin
        timed_out = 1'b0;
        break;
      end
    end
    w_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; fetch_start = 1'b0; weight_num = 8'd0; pixel_num = 8'd0;
    wr_ptr = 8'd0; load_done = 1'b1; w_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (raddr !== 8'd0) begin errors++; $display("FAIL reset_raddr got=%0h exp=0", raddr); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_w_valid got=%b exp=0", w_valid); end
    checks++; if (w_last !== 1'b0 || w_final !== 1'b0) begin errors++; $display("FAIL reset_tags got=%b%b exp=00", w_last, w_final); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int bad;
    for (int a = 0; a < 256; a++) mem[a] = 16'h10 + 16'(a);
    run_stream(4, 2, 100, 1'b0, -1, -1);
    bad = count_bad(4, 2);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL basic_beats got=%0d exp=8", obs_q.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_data bad_beats=%0d exp=0", bad); end
    checks++; if (first_valid_cyc != 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", first_valid_cyc); end
    checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy_c1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc != last_pop_cyc + 2) begin errors++; $display("FAIL basic_done_time got=%0d exp=%0d", done_cyc, last_pop_cyc + 2); end
    checks++; if (done_busy_bad != 0) begin errors++; $display("FAIL basic_busy_at_done got=%0d exp=0", done_busy_bad); end
  endtask

  task automatic test_back_pressure;
    int bad;
    int wn;
    int pn;
    run_stream(4, 2, 50, 1'b0, -1, -1);
    bad = count_bad(4, 2);
    checks++; if (bad != 0 || timed_out) begin errors++; $display("FAIL bp_data bad_beats=%0d timeout=%0d exp=0", bad, timed_out); end
    checks++; if (stall_breaks != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stall_breaks); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom_range(16'h7FFF));
      wn = int'($urandom_range(20, 1));
      pn = int'($urandom_range(3, 1));
      run_stream(wn, pn, 30 + 20 * t, 1'b0, -1, -1);
      bad = count_bad(wn, pn);
      checks++; if (bad != 0 || timed_out) begin errors++; $display("FAIL bp_rand wn=%0d pn=%0d bad_beats=%0d exp=0", wn, pn, bad); end
      checks++; if (stall_breaks != 0 || done_cnt != 1) begin errors++; $display("FAIL bp_rand_ctl stall_breaks=%0d done_cnt=%0d exp=0,1", stall_breaks, done_cnt); end
    end
  endtask

  task automatic test_wr_ptr_gating;
    int bad;
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom_range(16'h7FFF));
    run_stream(6, 2, 100, 1'b1, -1, -1);
    bad = count_bad(6, 2);
    checks++; if (bad != 0 || timed_out) begin errors++; $display("FAIL gate_data bad_beats=%0d timeout=%0d exp=0", bad, timed_out); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL gate_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (first_valid_cyc < 5) begin errors++; $display("FAIL gate_latency got=%0d exp>=5", first_valid_cyc); end
    load_done = 1'b1;
  endtask

  task automatic test_zero_count;
    for (int z = 0; z < 2; z++) begin
      weight_num = (z == 0) ? 8'd0 : 8'd5;
      pixel_num = (z == 0) ? 8'd3 : 8'd0;
      fetch_start = 1'b1;
      @(posedge clk); #1;
      fetch_start = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
        errors++; $display("FAIL zero_pulse%0d got done/busy/valid=%b%b%b exp=100", z, done, busy, w_valid); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0) begin
        errors++; $display("FAIL zero_after%0d got done/busy/valid=%b%b%b exp=000", z, done, busy, w_valid); end
    end
  endtask

  task automatic test_reset_mid_run;
    int bad;
    for (int a = 0; a < 256; a++) mem[a] = 16'h10 + 16'(a);
    run_stream(4, 2, 100, 1'b0, -1, 3);
    rst = 1'b1;
    #1;
    checks++; if (raddr !== 8'd0 || w_valid !== 1'b0 || w_last !== 1'b0 || w_final !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got raddr=%0h v=%b l=%b f=%b busy=%b done=%b exp all 0", raddr, w_valid, w_last, w_final, busy, done); end
    w_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("FAIL midrst_hold got done=%b v=%b exp=0,0", done, w_valid); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_stream(4, 2, 100, 1'b0, -1, -1);
    bad = count_bad(4, 2);
    checks++; if (bad != 0 || timed_out) begin errors++; $display("FAIL midrst_replay bad_beats=%0d exp=0", bad); end
    checks++; if (done_cnt != 1 || first_valid_cyc != 3) begin errors++; $display("FAIL midrst_ctl done_cnt=%0d first_valid=%0d exp=1,3", done_cnt, first_valid_cyc); end
  endtask

  task automatic test_start_while_busy;
    int bad;
    run_stream(4, 2, 70, 1'b0, 5, -1);
    bad = count_bad(4, 2);
    checks++; if (bad != 0 || timed_out) begin errors++; $display("FAIL busy_start_data bad_beats=%0d beats=%0d exp=0,8", bad, obs_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_wr_ptr_gating();
    test_zero_count();
    test_reset_mid_run();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
